dmux_stream: RTL and testbench

//  Parametrised 1:NCH stream demultiplexer; next generation of the structural dmux2/dmux8/dmux16 family.

---
 rtl/dmux_stream_pkg.sv | 21 ++
 rtl/dmux_stream_dec_onehot.sv | 24 ++
 rtl/dmux_stream.sv | 100 ++++++++++
 tb/tb_dmux_stream.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmux_stream_pkg.sv
// Shared types and helpers for the dmux stream family.
package dmux_stream_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmux_stream_dec_onehot.sv
// Binary-to-one-hot decoder with enable; flags select values beyond the last channel.
module dec_onehot
    import dmux_stream_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [clog2(N)-1:0] sel_i,
    input  logic                en_i,
    output logic [N-1:0]        onehot_o,
    output logic                oor_o
);

    localparam int SW = clog2(N);

    always_comb begin
        onehot_o = '0;
        for (int k = 0; k < N; k++) begin
            if (en_i && (sel_i == SW'(k))) onehot_o[k] = 1'b1;
        end
    end

    assign oor_o = ({1'b0, sel_i} >= (SW + 1)'(N));

endmodule

// File: rtl/dmux_stream.sv
// 1:NCH valid/ready demultiplexer with one registered slice and optional packet channel lock.
module dmux_stream
    import dmux_stream_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NCH    = 16,
    parameter int PACKET = 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [clog2(NCH)-1:0]  s,
    input  logic [WIDTH-1:0]       d,
    input  logic                   d_valid,
    input  logic                   d_last,
    output logic                   d_ready,
    output logic [NCH*WIDTH-1:0]   z,
    output logic [NCH-1:0]         z_valid,
    output logic [NCH-1:0]         z_last,
    input  logic [NCH-1:0]         z_ready,
    output logic                   busy,
    output logic                   err
);

    localparam int SELW = clog2(NCH);

    state_e            state_q, state_d;
    logic [SELW-1:0]   lock_q, lock_d;
    logic [SELW-1:0]   och_q;
    logic [SELW-1:0]   ch;
    logic [WIDTH-1:0]  data_q;
    logic              last_q;
    logic              loaded_q;
    logic              accept;
    logic              oor;
    logic [NCH-1:0]    onehot;

    assign ch = ((PACKET != 0) && (state_q == ST_PKT)) ? lock_q : s;

    // A loaded beat with an out-of-range channel decodes to no lane, so it
    // never qualifies an output and drains on the next cycle as an err pulse.
    dec_onehot #(.N(NCH)) u_dec (
        .sel_i    (och_q),
        .en_i     (loaded_q),
        .onehot_o (onehot),
        .oor_o    (oor)
    );

    assign d_ready = ~(|onehot) | (|(onehot & z_ready));
    assign accept  = d_valid & d_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        if ((PACKET != 0) && accept) begin
            if (state_q == ST_IDLE) begin
                if (!d_last) begin
                    state_d = ST_PKT;
                    lock_d  = s;
                end
            end else if (d_last) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        busy = (state_q == ST_PKT);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_q   <= '0;
            och_q    <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
            if (accept) begin
                och_q    <= ch;
                data_q   <= d;
                last_q   <= d_last;
                loaded_q <= 1'b1;
            end else if (d_ready) begin
                loaded_q <= 1'b0;
            end
        end
    end

    assign z       = {NCH{data_q}};
    assign z_valid = onehot;
    assign z_last  = onehot & {NCH{last_q}};
    assign err     = loaded_q & oor;

endmodule

// File: tb/tb_dmux_stream.sv
// Scoreboard bench for dmux_stream: three configurations, directed vectors plus a packet soak.
module tb_dmux_stream;

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;

    logic [3:0]   sA;
    logic [7:0]   dA;
    logic         vA, lA, rA, bA, eA;
    logic [127:0] zA;
    logic [15:0]  zvA, zlA, zrA;

    logic [3:0]   sB;
    logic [7:0]   dB;
    logic         vB, lB, rB, bB, eB;
    logic [79:0]  zB;
    logic [9:0]   zvB, zlB, zrB;

    logic [2:0]   sC;
    logic [7:0]   dC;
    logic         vC, lC, rC, bC, eC;
    logic [39:0]  zC;
    logic [4:0]   zvC, zlC, zrC;

    exp_t  q [3][$];
    string nm [3] = '{"A", "B", "C"};
    int    nchk = 0;
    int    nerr = 0;
    bit    soak_on = 1'b0;

    logic [7:0] t4_s [4] = '{8'd2, 8'd7, 8'd7, 8'd7};
    logic [7:0] t4_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    dmux_stream #(.WIDTH(8), .NCH(16), .PACKET(0)) u_a (
        .clk(clk), .rstn(rstn), .s(sA), .d(dA), .d_valid(vA), .d_last(lA),
        .d_ready(rA), .z(zA), .z_valid(zvA), .z_last(zlA), .z_ready(zrA),
        .busy(bA), .err(eA)
    );

    dmux_stream #(.WIDTH(8), .NCH(10), .PACKET(1)) u_b (
        .clk(clk), .rstn(rstn), .s(sB), .d(dB), .d_valid(vB), .d_last(lB),
        .d_ready(rB), .z(zB), .z_valid(zvB), .z_last(zlB), .z_ready(zrB),
        .busy(bB), .err(eB)
    );

    dmux_stream #(.WIDTH(8), .NCH(5), .PACKET(1)) u_c (
        .clk(clk), .rstn(rstn), .s(sC), .d(dC), .d_valid(vC), .d_last(lC),
        .d_ready(rC), .z(zC), .z_valid(zvC), .z_last(zlC), .z_ready(zrC),
        .busy(bC), .err(eC)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon(input int w, input logic [15:0] zv, input logic [15:0] zr,
                       input logic [15:0] zl, input logic [127:0] z);
        logic [15:0] x;
        int          k;
        exp_t        e;
        x = zv & zr;
        if (zv != 16'h0) chk({nm[w], "_onehot"}, $countones(zv) <= 1, 1);
        if (x != 16'h0) begin
            k = 0;
            for (int i = 0; i < 16; i++) if (x[i]) k = i;
            chk({nm[w], "_expected_beat"}, q[w].size() > 0, 1);
            if (q[w].size() > 0) begin
                e = q[w].pop_front();
                chk({nm[w], "_ch"},   k,            e.ch);
                chk({nm[w], "_data"}, z[k*8 +: 8],  e.data);
                chk({nm[w], "_last"}, zl[k],        e.last);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            mon(0, zvA, zrA, zlA, zA);
            mon(1, 16'(zvB), 16'(zrB), 16'(zlB), 128'(zB));
            mon(2, 16'(zvC), 16'(zrC), 16'(zlC), 128'(zC));
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (soak_on) zrC = 5'($urandom_range(0, 31));
    end

    task automatic send_c(input logic [7:0] s, input logic [7:0] d, input logic l, input int ech);
        int   n;
        logic rdy;
        sC = s[2:0]; dC = d; lC = l; vC = 1'b1;
        n = 0;
        rdy = 1'b0;
        forever begin
            @(negedge clk);
            rdy = rC;
            if (rdy || n >= 200) break;
            n++;
            @(posedge clk);
            #1;
        end
        chk("C_accept_timeout", rdy, 1);
        if (rdy) q[2].push_back('{ech, d, l});
        @(posedge clk);
        #1;
        vC = 1'b0;
    endtask

    initial begin
        int plen, pch;
        rstn = 1'b0;
        sA = '0; dA = '0; vA = 1'b0; lA = 1'b0; zrA = '1;
        sB = '0; dB = '0; vB = 1'b0; lB = 1'b0; zrB = '1;
        sC = '0; dC = '0; vC = 1'b0; lC = 1'b0; zrC = '1;

        // reset state
        #3;
        chk("rst_zvA", zvA, 0); chk("rst_zA", zA, 0); chk("rst_errA", eA, 0);
        chk("rst_zvB", zvB, 0); chk("rst_busyB", bB, 0); chk("rst_zlB", zlB, 0);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        chk("rst_rdyA", rA, 1); chk("rst_rdyB", rB, 1); chk("rst_rdyC", rC, 1);

        // PACKET=0 back-to-back beats on channels 3 and 15
        @(posedge clk); #1; sA = 4'd3; dA = 8'hA5; lA = 1'b0; vA = 1'b1;
        @(negedge clk); chk("t2_rdy1", rA, 1); q[0].push_back('{3, 8'hA5, 1'b0});
        @(posedge clk); #1; sA = 4'd15; dA = 8'h5A;
        @(negedge clk);
        chk("t2_zv1", zvA, 16'h0008); chk("t2_lane3", zA[24 +: 8], 8'hA5); chk("t2_rdy2", rA, 1);
        q[0].push_back('{15, 8'h5A, 1'b0});
        @(posedge clk); #1; vA = 1'b0;
        @(negedge clk);
        chk("t2_zv2", zvA, 16'h8000); chk("t2_lane15", zA[120 +: 8], 8'h5A); chk("t2_rdy3", rA, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("t2_idle", zvA, 16'h0000);

        // backpressure on channel 3, reload on the releasing cycle
        @(posedge clk); #1; zrA = 16'hFFF7; sA = 4'd3; dA = 8'h3C; vA = 1'b1;
        @(negedge clk); chk("t3_rdy0", rA, 1); q[0].push_back('{3, 8'h3C, 1'b0});
        @(posedge clk); #1; sA = 4'd4; dA = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_hold_zv", zvA, 16'h0008);
            chk("t3_hold_z", zA, {16{8'h3C}});
            chk("t3_hold_rdy", rA, 0);
            @(posedge clk); #1;
        end
        zrA = '1;
        @(negedge clk);
        chk("t3_rel_rdy", rA, 1); chk("t3_rel_zv", zvA, 16'h0008);
        q[0].push_back('{4, 8'hC3, 1'b0});
        @(posedge clk); #1; vA = 1'b0;
        @(negedge clk); chk("t3_next_zv", zvA, 16'h0010); chk("t3_lane4", zA[32 +: 8], 8'hC3);

        // PACKET=1: four-beat packet locked to channel 2
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; sB = t4_s[i][3:0]; dB = t4_d[i]; lB = (i == 3); vB = 1'b1;
            @(negedge clk);
            chk("t4_rdy", rB, 1);
            chk("t4_busy", bB, i > 0);
            if (i > 0) begin
                chk("t4_zv", zvB, 10'h004);
                chk("t4_zl", zlB, 10'h000);
            end
            q[1].push_back('{2, t4_d[i], i == 3});
        end
        @(posedge clk); #1; vB = 1'b0;
        @(negedge clk); chk("t4_busy_end", bB, 0); chk("t4_zv_end", zvB, 10'h004); chk("t4_zl_end", zlB, 10'h004);

        // invalid channel: single beat, then a two-beat bad packet
        @(posedge clk); #1; sB = 4'd12; dB = 8'h77; lB = 1'b1; vB = 1'b1;
        @(negedge clk); chk("t5_rdy", rB, 1);
        @(posedge clk); #1; vB = 1'b0;
        @(negedge clk); chk("t5_err", eB, 1); chk("t5_zv", zvB, 0); chk("t5_rdy2", rB, 1);
        @(negedge clk); chk("t5_err_off", eB, 0);
        @(posedge clk); #1; sB = 4'd11; dB = 8'h88; lB = 1'b0; vB = 1'b1;
        @(negedge clk); chk("t5b_rdy", rB, 1); chk("t5b_err0", eB, 0);
        @(posedge clk); #1; sB = 4'd5; dB = 8'h99; lB = 1'b1;
        @(negedge clk); chk("t5b_err1", eB, 1); chk("t5b_busy", bB, 1); chk("t5b_zv1", zvB, 0); chk("t5b_rdy2", rB, 1);
        @(posedge clk); #1; vB = 1'b0;
        @(negedge clk); chk("t5b_err2", eB, 1); chk("t5b_busy_end", bB, 0); chk("t5b_zv2", zvB, 0);
        @(negedge clk); chk("t5b_err_off", eB, 0);

        // reset mid-packet with a held output beat
        @(posedge clk); #1; zrB = 10'h3BF; sB = 4'd6; dB = 8'h66; lB = 1'b0; vB = 1'b1;
        @(negedge clk); chk("t1_rdy", rB, 1);
        @(posedge clk); #1; vB = 1'b0;
        @(negedge clk); chk("t1_busy", bB, 1); chk("t1_zv", zvB, 10'h040);
        #2 rstn = 1'b0;
        #1;
        chk("t1_rst_zv", zvB, 0); chk("t1_rst_busy", bB, 0); chk("t1_rst_err", eB, 0); chk("t1_rst_z", zB, 0);
        for (int w = 0; w < 3; w++) q[w].delete();
        @(negedge clk); #2 rstn = 1'b1; zrB = '1;
        @(posedge clk); #1; sB = 4'd1; dB = 8'h5E; lB = 1'b1; vB = 1'b1;
        @(negedge clk); chk("t1_post_rdy", rB, 1); q[1].push_back('{1, 8'h5E, 1'b1});
        @(posedge clk); #1; vB = 1'b0;
        @(negedge clk); chk("t1_post_zv", zvB, 10'h002); chk("t1_post_busy", bB, 0);

        // random soak on NCH=5 with packet lengths 1..8
        @(posedge clk); #1; soak_on = 1'b1;
        for (int p = 0; p < 40; p++) begin
            plen = $urandom_range(1, 8);
            pch  = $urandom_range(0, 4);
            for (int b = 0; b < plen; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
                send_c((b == 0) ? 8'(pch) : 8'($urandom_range(0, 7)), 8'($urandom), b == plen - 1, pch);
            end
        end
        soak_on = 1'b0;
        zrC = '1;
        repeat (10) @(negedge clk);
        chk("drain_A", q[0].size(), 0);
        chk("drain_B", q[1].size(), 0);
        chk("drain_C", q[2].size(), 0);
        chk("soak_busy_end", bC, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
